// File: rtl/switch_poll_ctrl_pkg.sv
// switch_poll_pkg
//   Shared types and constants for the switch polling controller.
//   - poll_state_t     : poll sequencer states
//   - PIO_DATA_OFFSET  : address of the PIO data register
//   - PIO_READ_LATENCY : cycles from read strobe to valid readdata
//   - cnt_width()      : bit width needed for a counter holding values 0..n-1
package switch_poll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } poll_state_t;

  localparam logic [1:0] PIO_DATA_OFFSET  = 2'd0;
  localparam int         PIO_READ_LATENCY = 1;

  // Width of a counter that must represent 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/switch_poll_ctrl_if.sv
// switch_poll_ctrl_if
//   Bundles the Avalon-MM read path to the switch PIO and the single-entry
//   event handshake to the consumer.
//   Avalon : m_address, m_read (master drives), m_readdata (slave drives)
//   Event  : ev_valid, ev_data, ev_changed (master drives), ev_ready (consumer)
//   modport master : the polling controller's view
//   modport slave  : the PIO slave and event consumer's view
interface switch_poll_ctrl_if
  import switch_poll_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [1:0]        m_address;
  logic              m_read;
  logic [31:0]       m_readdata;
  logic              ev_valid;
  logic              ev_ready;
  logic [DATA_W-1:0] ev_data;
  logic [DATA_W-1:0] ev_changed;

  modport master (
    output m_address,
    output m_read,
    input  m_readdata,
    output ev_valid,
    input  ev_ready,
    output ev_data,
    output ev_changed
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_readdata,
    input  ev_valid,
    output ev_ready,
    input  ev_data,
    input  ev_changed
  );

endinterface

// File: rtl/switch_poll_ctrl_sw_debounce_filter.sv
// sw_debounce_filter
//   Accepts a new switch value only after STABLE_N consecutive identical
//   samples. Produces a one-cycle change pulse, in the same cycle as the
//   sample strobe, when the accepted value differs from the current one.
//   Ports:
//     clk, reset_n  : clock, synchronous active-low reset
//     sample_valid  : a new sample is presented this cycle
//     sample        : sampled switch value
//     stable_state  : current debounced value
//     change        : pulse, accepted value changes at the next edge
//     change_value  : the newly accepted value (valid with change)
//     change_mask   : bits that differ from the old debounced value
module sw_debounce_filter
  import switch_poll_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int STABLE_N = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] stable_state,
  output logic              change,
  output logic [DATA_W-1:0] change_value,
  output logic [DATA_W-1:0] change_mask
);

  localparam int CNT_W = cnt_width(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_N);

  logic [DATA_W-1:0] candidate_reg;
  logic [DATA_W-1:0] candidate_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] stable_reg;
  logic              fire;

  // Count saturates so a held value can never re-trigger an event.
  always_comb begin
    candidate_next = candidate_reg;
    count_next     = count_reg;
    if (sample == candidate_reg) begin
      if (count_reg != CNT_MAX) begin
        count_next = count_reg + CNT_W'(1);
      end
    end else begin
      candidate_next = sample;
      count_next     = CNT_W'(1);
    end
  end

  assign fire = sample_valid && (count_next == CNT_MAX) &&
                (candidate_next != stable_reg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      candidate_reg <= '0;
      count_reg     <= '0;
      stable_reg    <= '0;
    end else if (sample_valid) begin
      candidate_reg <= candidate_next;
      count_reg     <= count_next;
      if (fire) begin
        stable_reg <= candidate_next;
      end
    end
  end

  assign stable_state = stable_reg;
  assign change       = fire;
  assign change_value = candidate_next;
  assign change_mask  = candidate_next ^ stable_reg;

endmodule

// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl
//   Avalon-MM master that polls the switch PIO data register at a fixed
//   interval, debounces the samples and presents each debounced change as
//   an event on a single-entry valid/ready interface.
//   Ports:
//     clk, reset_n   : clock, synchronous active-low reset
//     enable         : 1 = polling runs, 0 = no new polls start
//     bus            : Avalon read path + event handshake (master modport)
//     stable_state   : current debounced switch value
//     overrun        : sticky, an event arrived while one was still pending
//     clear_overrun  : clears overrun (a simultaneous new overrun wins)
module switch_poll_ctrl
  import switch_poll_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int POLL_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  switch_poll_ctrl_if.master   bus,
  output logic [DATA_W-1:0]    stable_state,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam int TIMER_W = cnt_width(POLL_DIV);
  // Full interval after reset or while disabled.
  localparam logic [TIMER_W-1:0] RELOAD_IDLE = TIMER_W'(POLL_DIV - 1);
  // After a poll, the READ and capture cycles already used part of the
  // interval, so the idle countdown is shortened to keep strobes exactly
  // POLL_DIV cycles apart.
  localparam logic [TIMER_W-1:0] RELOAD_POLL =
    TIMER_W'(POLL_DIV - 2 - PIO_READ_LATENCY);

  poll_state_t        state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               m_read_reg;

  logic              ev_valid_reg;
  logic [DATA_W-1:0] ev_data_reg;
  logic [DATA_W-1:0] ev_changed_reg;
  logic              overrun_reg;

  logic              sample_valid;
  logic              change;
  logic [DATA_W-1:0] change_value;
  logic [DATA_W-1:0] change_mask;

  // --------------------------------------------------------------------
  // Poll sequencer
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      timer_reg  <= RELOAD_IDLE;
      m_read_reg <= 1'b0;
    end else begin
      m_read_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!enable) begin
            timer_reg <= RELOAD_IDLE;
          end else if (timer_reg == '0) begin
            state_reg  <= READ;
            m_read_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg - TIMER_W'(1);
          end
        end
        READ: begin
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          state_reg <= IDLE;
          timer_reg <= RELOAD_POLL;
        end
        default: begin
          state_reg <= IDLE;
          timer_reg <= RELOAD_IDLE;
        end
      endcase
    end
  end

  assign bus.m_read    = m_read_reg;
  assign bus.m_address = PIO_DATA_OFFSET;

  // readdata is valid in the cycle after the strobe, which is CAPTURE.
  assign sample_valid = (state_reg == CAPTURE);

  // Only the low DATA_W bits carry switch state.
  generate
    if (DATA_W < 32) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^bus.m_readdata[31:DATA_W];
    end
  endgenerate

  sw_debounce_filter #(
    .DATA_W   (DATA_W),
    .STABLE_N (STABLE_N)
  ) u_filter (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (bus.m_readdata[DATA_W-1:0]),
    .stable_state (stable_state),
    .change       (change),
    .change_value (change_value),
    .change_mask  (change_mask)
  );

  // --------------------------------------------------------------------
  // Single-entry event register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ev_valid_reg   <= 1'b0;
      ev_data_reg    <= '0;
      ev_changed_reg <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      if (change) begin
        ev_valid_reg <= 1'b1;
        ev_data_reg  <= change_value;
        if (ev_valid_reg && !bus.ev_ready) begin
          // Pending event not taken: coalesce so no changed bit is lost.
          ev_changed_reg <= ev_changed_reg | change_mask;
        end else begin
          ev_changed_reg <= change_mask;
        end
      end else if (ev_valid_reg && bus.ev_ready) begin
        ev_valid_reg <= 1'b0;
      end

      if (change && ev_valid_reg && !bus.ev_ready) begin
        overrun_reg <= 1'b1;
      end else if (clear_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.ev_valid   = ev_valid_reg;
  assign bus.ev_data    = ev_data_reg;
  assign bus.ev_changed = ev_changed_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_switch_poll_ctrl.sv
module tb_switch_poll_ctrl;

  localparam int DATA_W   = 8;
  localparam int POLL_DIV = 8;
  localparam int STABLE_N = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [DATA_W-1:0] stable_state;
  logic              overrun;
  logic              clear_overrun;
  logic [31:0]       rd_value;

  switch_poll_ctrl_if #(.DATA_W(DATA_W)) bus ();

  switch_poll_ctrl #(
    .DATA_W   (DATA_W),
    .POLL_DIV (POLL_DIV),
    .STABLE_N (STABLE_N)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bus           (bus),
    .stable_state  (stable_state),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model: registered readdata, valid only the cycle after a strobe.
  always @(posedge clk) begin
    if (bus.m_read) bus.m_readdata <= rd_value;
    else            bus.m_readdata <= 32'hDEAD_BEEF;
  end

  int tests  = 0;
  int failed = 0;
  int last_strobe = -1;

  task automatic expect_eq(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // mode: 0 = ev_ready low, 1 = ev_ready high, 2 = high only in capture cycle
  typedef struct {
    logic [31:0] rd;
    int          mode;
    logic        valid;
    logic [7:0]  data;
    logic [7:0]  changed;
    logic [7:0]  stable;
    logic        ovr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [31:0] rd, input int mode, input logic valid,
                     input logic [7:0] data, input logic [7:0] changed,
                     input logic [7:0] stable, input logic ovr);
    vec_t v;
    v.rd = rd; v.mode = mode; v.valid = valid; v.data = data;
    v.changed = changed; v.stable = stable; v.ovr = ovr;
    vq.push_back(v);
  endtask

  task automatic wait_strobe(output bit ok);
    int n = 0;
    while (!bus.m_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.m_read;
  endtask

  // Runs one poll: checks strobe timing, then outputs two cycles after it.
  task automatic do_poll(input int idx, input vec_t v);
    bit ok;
    rd_value     = v.rd;
    bus.ev_ready = (v.mode == 1);
    wait_strobe(ok);
    expect_eq("strobe_seen", 32'(ok), 32'd1);
    if (!ok) return;
    expect_eq("m_address", 32'(bus.m_address), 32'd0);
    if (last_strobe >= 0) expect_eq("strobe_interval", cyc - last_strobe, POLL_DIV);
    last_strobe = cyc;
    @(negedge clk);
    expect_eq("strobe_width", 32'(bus.m_read), 32'd0);
    if (v.mode == 2) bus.ev_ready = 1'b1;
    @(negedge clk);
    expect_eq("ev_valid", 32'(bus.ev_valid), 32'(v.valid));
    expect_eq("ev_data", 32'(bus.ev_data), 32'(v.data));
    expect_eq("ev_changed", 32'(bus.ev_changed), 32'(v.changed));
    expect_eq("stable_state", 32'(stable_state), 32'(v.stable));
    expect_eq("overrun", 32'(overrun), 32'(v.ovr));
    $display("[TB] poll %0d rd=%08h mode=%0d ev_valid=%0b ev_data=%02h ev_changed=%02h stable=%02h overrun=%0b",
             idx, v.rd, v.mode, bus.ev_valid, bus.ev_data, bus.ev_changed,
             stable_state, overrun);
    bus.ev_ready = (v.mode == 1);
  endtask

  task automatic check_reset_values(input string tag);
    expect_eq({tag, "_m_read"}, 32'(bus.m_read), 32'd0);
    expect_eq({tag, "_m_address"}, 32'(bus.m_address), 32'd0);
    expect_eq({tag, "_ev_valid"}, 32'(bus.ev_valid), 32'd0);
    expect_eq({tag, "_ev_data"}, 32'(bus.ev_data), 32'd0);
    expect_eq({tag, "_ev_changed"}, 32'(bus.ev_changed), 32'd0);
    expect_eq({tag, "_stable"}, 32'(stable_state), 32'd0);
    expect_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    $display("[TB] %s ev_valid=%0b ev_data=%02h stable=%02h overrun=%0b",
             tag, bus.ev_valid, bus.ev_data, stable_state, overrun);
  endtask

  // Counts cycles from now until the next strobe (bounded).
  task automatic cycles_to_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_read && n < 40);
  endtask

  initial begin
    int n;
    int strobes;
    bit ok;

    reset_n       = 1'b0;
    enable        = 1'b1;
    clear_overrun = 1'b0;
    rd_value      = 32'h0;
    bus.ev_ready  = 1'b1;

    // Vectors: rd, mode, valid, data, changed, stable, overrun
    add(32'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0);       // idle at 0x00
    add(32'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(32'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(32'h05, 1, 0, 8'h00, 8'h00, 8'h00, 0);       // step to 0x05
    add(32'h05, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(32'h05, 1, 1, 8'h05, 8'h05, 8'h05, 0);       // 3rd match fires
    add(32'h05, 1, 0, 8'h05, 8'h05, 8'h05, 0);       // no repeat event
    add(32'h05, 1, 0, 8'h05, 8'h05, 8'h05, 0);       // bounce 05/04
    add(32'h04, 1, 0, 8'h05, 8'h05, 8'h05, 0);
    add(32'h05, 1, 0, 8'h05, 8'h05, 8'h05, 0);
    add(32'h04, 1, 0, 8'h05, 8'h05, 8'h05, 0);
    add(32'h0F, 0, 0, 8'h05, 8'h05, 8'h05, 0);       // consumer stalled
    add(32'h0F, 0, 0, 8'h05, 8'h05, 8'h05, 0);
    add(32'h0F, 0, 1, 8'h0F, 8'h0A, 8'h0F, 0);
    add(32'hF0, 0, 1, 8'h0F, 8'h0A, 8'h0F, 0);
    add(32'hF0, 0, 1, 8'h0F, 8'h0A, 8'h0F, 0);
    add(32'hF0, 0, 1, 8'hF0, 8'hFF, 8'hF0, 1);       // coalesced + overrun

    // Reset phase
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) do_poll(i, vq[i]);

    // Clear overrun while accepting the pending event.
    clear_overrun = 1'b1;
    bus.ev_ready  = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    bus.ev_ready  = 1'b0;
    expect_eq("clear_overrun", 32'(overrun), 32'd0);
    expect_eq("accept_ev_valid", 32'(bus.ev_valid), 32'd0);
    expect_eq("accept_ev_data", 32'(bus.ev_data), 32'hF0);
    $display("[TB] clear_overrun overrun=%0b ev_valid=%0b", overrun, bus.ev_valid);

    // Accept-and-reload in the same cycle, then upper readdata bits.
    vq.delete();
    add(32'h3C, 0, 0, 8'hF0, 8'hFF, 8'hF0, 0);
    add(32'h3C, 0, 0, 8'hF0, 8'hFF, 8'hF0, 0);
    add(32'h3C, 0, 1, 8'h3C, 8'hCC, 8'h3C, 0);
    add(32'h3D, 0, 1, 8'h3C, 8'hCC, 8'h3C, 0);
    add(32'h3D, 0, 1, 8'h3C, 8'hCC, 8'h3C, 0);
    add(32'h3D, 2, 1, 8'h3D, 8'h01, 8'h3D, 0);       // fresh load, no overrun
    add(32'hABCD_0012, 1, 0, 8'h3D, 8'h01, 8'h3D, 0);
    add(32'hABCD_0012, 1, 0, 8'h3D, 8'h01, 8'h3D, 0);
    add(32'hABCD_0012, 1, 1, 8'h12, 8'h2F, 8'h12, 0);
    add(32'h5555_0012, 1, 0, 8'h12, 8'h2F, 8'h12, 0); // upper bits ignored
    for (int i = 0; i < vq.size(); i++) do_poll(100 + i, vq[i]);

    // Reset asserted in the READ cycle.
    rd_value = 32'h77;
    wait_strobe(ok);
    expect_eq("pre_reset_strobe", 32'(ok), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_in_read");
    reset_n = 1'b1;
    cycles_to_strobe(n);
    expect_eq("first_strobe_after_reset", n, POLL_DIV);
    $display("[TB] reset release -> first strobe after %0d cycles", n);
    @(negedge clk);
    @(negedge clk);
    expect_eq("post_reset_ev_valid", 32'(bus.ev_valid), 32'd0);
    expect_eq("post_reset_stable", 32'(stable_state), 32'd0);

    // Enable dropped mid-count.
    @(negedge clk);
    enable  = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_read) strobes++;
    end
    expect_eq("disabled_strobes", strobes, 0);
    $display("[TB] enable=0 for 20 cycles -> %0d strobes", strobes);
    enable = 1'b1;
    cycles_to_strobe(n);
    expect_eq("first_strobe_after_enable", n, POLL_DIV);
    $display("[TB] enable=1 -> first strobe after %0d cycles", n);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
